// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the MEM-stage load/store unit.
//   - funct3 encodings for loads/stores
//   - FSM state enum and access-size enum
//   - byte-enable width and a funct3 -> access-size decode helper
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int BE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } lsu_size_e;

  // Any funct3 outside the byte/half encodings is treated as a word access.
  function automatic lsu_size_e size_of(input logic [2:0] f3);
    lsu_size_e sz;
    case (f3)
      F3_B, F3_BU: sz = SZ_B;
      F3_H, F3_HU: sz = SZ_H;
      default:     sz = SZ_W;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: combinational load-data formatter.
// Ports:
//   rdata  [31:0] raw word returned by data memory
//   off    [1:0]  byte offset of the access inside the word
//   funct3 [2:0]  load type (LB/LH/LW/LBU/LHU)
//   data   [31:0] lane-selected, sign/zero-extended load value
import lsu_pkg::*;

module lsu_load_align (
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed byte and half lanes out of the word.
  always_comb begin
    byte_s = rdata[7:0];
    case (off)
      2'd0:    byte_s = rdata[7:0];
      2'd1:    byte_s = rdata[15:8];
      2'd2:    byte_s = rdata[23:16];
      2'd3:    byte_s = rdata[31:24];
      default: byte_s = rdata[7:0];
    endcase
    if (off[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
  end

  // Extend the selected lane according to the load type.
  always_comb begin
    data = rdata;
    case (funct3)
      F3_B:    data = {{24{byte_s[7]}}, byte_s};
      F3_BU:   data = {24'd0, byte_s};
      F3_H:    data = {{16{half_s[15]}}, half_s};
      F3_HU:   data = {16'd0, half_s};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: MEM-stage load/store unit (IDLE -> BUSY -> DONE).
// Turns EX/MEM load/store controls into a registered valid/ack memory
// request, formats load data for MEM/WB, and stalls the pipe while busy.
// Ports:
//   i_clk, i_reset (async, active-low)
//   i_valid, i_mem_rd, i_mem_wr, i_funct3, i_addr, i_wdata : EX/MEM controls
//   o_dmem_req/we/addr/wdata/be, i_dmem_ack, i_dmem_rdata : memory port
//   o_ld_data : formatted load result, o_stall : MEM busy
//   o_misalign : only with LSU_MISALIGN_TRAP_EN defined; flags a misaligned
//                half/word access, which is then not issued. Without the
//                macro, misaligned accesses are force-aligned.
import lsu_pkg::*;

module lsu_mem_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  input  logic              i_mem_rd,
  input  logic              i_mem_wr,
  input  logic [2:0]        i_funct3,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic              o_dmem_req,
  output logic              o_dmem_we,
  output logic [ADDR_W-1:0] o_dmem_addr,
  output logic [31:0]       o_dmem_wdata,
  output logic [BE_W-1:0]   o_dmem_be,
  input  logic              i_dmem_ack,
  input  logic [31:0]       i_dmem_rdata,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic              o_misalign,
`endif
  output logic [31:0]       o_ld_data,
  output logic              o_stall
);

  lsu_state_e        state_r, state_nxt_s;
  lsu_size_e         size_s;
  logic              acc_s, misalign_s, issue_s;
  logic [1:0]        off_s;
  logic [BE_W-1:0]   be_s;
  logic [31:0]       wdata_s, ld_fmt_s;

  logic              req_r, we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r, ld_data_r;
  logic [BE_W-1:0]   be_r;
  logic [2:0]        funct3_r;
  logic [1:0]        off_r;

  assign acc_s  = i_valid & (i_mem_rd | i_mem_wr);
  assign off_s  = i_addr[1:0];
  assign size_s = size_of(i_funct3);

`ifdef LSU_MISALIGN_TRAP_EN
  // Flag misaligned half/word accesses detected in IDLE.
  always_comb begin
    misalign_s = 1'b0;
    if ((state_r == IDLE) && acc_s) begin
      case (size_s)
        SZ_H:    misalign_s = off_s[0];
        SZ_W:    misalign_s = (off_s != 2'b00);
        default: misalign_s = 1'b0;
      endcase
    end else begin
      misalign_s = 1'b0;
    end
  end
  assign o_misalign = misalign_s;
`else
  assign misalign_s = 1'b0;
`endif

  // A trapped access is never issued; the trap unit flushes it instead.
  assign issue_s = (state_r == IDLE) & acc_s & ~misalign_s;

  // Store lane replication and byte enables; loads always read the full word.
  always_comb begin
    be_s    = 4'b1111;
    wdata_s = i_wdata;
    if (i_mem_wr) begin
      case (size_s)
        SZ_B: begin
          be_s    = 4'b0001 << off_s;
          wdata_s = {4{i_wdata[7:0]}};
        end
        SZ_H: begin
          be_s    = 4'b0011 << {off_s[1], 1'b0};
          wdata_s = {2{i_wdata[15:0]}};
        end
        default: begin
          be_s    = 4'b1111;
          wdata_s = i_wdata;
        end
      endcase
    end else begin
      be_s    = 4'b1111;
      wdata_s = i_wdata;
    end
  end

  lsu_load_align u_load_align (
    .rdata  (i_dmem_rdata),
    .off    (off_r),
    .funct3 (funct3_r),
    .data   (ld_fmt_s)
  );

  // Next-state and stall decode.
  always_comb begin
    state_nxt_s = state_r;
    o_stall     = 1'b0;
    case (state_r)
      IDLE: begin
        o_stall = issue_s;
        if (issue_s) begin
          state_nxt_s = BUSY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        o_stall = 1'b1;
        if (i_dmem_ack) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      DONE: begin
        o_stall     = 1'b0;
        state_nxt_s = IDLE;
      end
      default: begin
        o_stall     = 1'b0;
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Request capture in IDLE, load-data capture on ack while BUSY.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      req_r     <= 1'b0;
      we_r      <= 1'b0;
      addr_r    <= '0;
      wdata_r   <= 32'd0;
      be_r      <= 4'b0000;
      funct3_r  <= 3'b000;
      off_r     <= 2'b00;
      ld_data_r <= 32'd0;
    end else if (issue_s) begin
      req_r    <= 1'b1;
      we_r     <= i_mem_wr;
      addr_r   <= {i_addr[ADDR_W-1:2], 2'b00};
      wdata_r  <= wdata_s;
      be_r     <= be_s;
      funct3_r <= i_funct3;
      off_r    <= off_s;
    end else if ((state_r == BUSY) && i_dmem_ack) begin
      req_r <= 1'b0;
      if (!we_r) begin
        ld_data_r <= ld_fmt_s;
      end
    end
  end

  assign o_dmem_req   = req_r;
  assign o_dmem_we    = we_r;
  assign o_dmem_addr  = addr_r;
  assign o_dmem_wdata = wdata_r;
  assign o_dmem_be    = be_r;
  assign o_ld_data    = ld_data_r;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: directed self-checking bench for lsu_mem_stage.
// Build with LSU_MISALIGN_TRAP_EN defined to exercise the trap port.
module tb_lsu_mem_stage;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_valid, i_mem_rd, i_mem_wr;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr, i_wdata;
  logic        o_dmem_req, o_dmem_we;
  logic [31:0] o_dmem_addr, o_dmem_wdata;
  logic [3:0]  o_dmem_be;
  logic        i_dmem_ack;
  logic [31:0] i_dmem_rdata;
  logic [31:0] o_ld_data;
  logic        o_stall;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        o_misalign;
`endif

  int total = 0;
  int bad   = 0;

  always #5 i_clk = ~i_clk;

  lsu_mem_stage #(.ADDR_W(32)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_valid      (i_valid),
    .i_mem_rd     (i_mem_rd),
    .i_mem_wr     (i_mem_wr),
    .i_funct3     (i_funct3),
    .i_addr       (i_addr),
    .i_wdata      (i_wdata),
    .o_dmem_req   (o_dmem_req),
    .o_dmem_we    (o_dmem_we),
    .o_dmem_addr  (o_dmem_addr),
    .o_dmem_wdata (o_dmem_wdata),
    .o_dmem_be    (o_dmem_be),
    .i_dmem_ack   (i_dmem_ack),
    .i_dmem_rdata (i_dmem_rdata),
`ifdef LSU_MISALIGN_TRAP_EN
    .o_misalign   (o_misalign),
`endif
    .o_ld_data    (o_ld_data),
    .o_stall      (o_stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // One access from IDLE through DONE back to IDLE; ack raised in BUSY cycle ack_cyc (1-based).
  task automatic run_acc(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                         input int ack_cyc, input logic [31:0] e_addr, input logic [3:0] e_be,
                         input logic [31:0] e_wdata, input logic [31:0] e_ld);
    int  stalls = 0;
    int  busy   = 0;
    bit  done   = 1'b0;
    i_valid = 1'b1; i_mem_rd = rd; i_mem_wr = wr; i_funct3 = f3; i_addr = addr; i_wdata = wdata;
    #1;
    if (o_stall) stalls++;
    chk({tag, "_idle_req"}, {31'd0, o_dmem_req}, 32'd0);
    for (int c = 0; c < 30 && !done; c++) begin
      tick();
      if (o_dmem_req) begin
        busy++;
        if (o_stall) stalls++;
        chk({tag, "_addr"}, o_dmem_addr, e_addr);
        chk({tag, "_be"}, {28'd0, o_dmem_be}, {28'd0, e_be});
        chk({tag, "_we"}, {31'd0, o_dmem_we}, {31'd0, wr});
        chk({tag, "_wdata"}, o_dmem_wdata, e_wdata);
        if (busy == ack_cyc) begin
          i_dmem_ack = 1'b1;
          i_dmem_rdata = rdata;
        end
      end else begin
        done = 1'b1;
        i_dmem_ack = 1'b0;
        i_valid = 1'b0; i_mem_rd = 1'b0; i_mem_wr = 1'b0;
        chk({tag, "_done_stall"}, {31'd0, o_stall}, 32'd0);
        chk({tag, "_ld"}, o_ld_data, e_ld);
      end
    end
    chk({tag, "_finished"}, {31'd0, done}, 32'd1);
    chk({tag, "_stall_cycles"}, stalls, ack_cyc + 1);
    tick();
    chk({tag, "_back_idle_stall"}, {31'd0, o_stall}, 32'd0);
    chk({tag, "_back_idle_req"}, {31'd0, o_dmem_req}, 32'd0);
  endtask

  initial begin
    i_reset = 1'b0;
    i_valid = 1'b0; i_mem_rd = 1'b0; i_mem_wr = 1'b0; i_funct3 = 3'b000;
    i_addr = 32'd0; i_wdata = 32'd0; i_dmem_ack = 1'b0; i_dmem_rdata = 32'd0;
    #12;
    chk("rst_req", {31'd0, o_dmem_req}, 32'd0);
    chk("rst_we", {31'd0, o_dmem_we}, 32'd0);
    chk("rst_be", {28'd0, o_dmem_be}, 32'd0);
    chk("rst_addr", o_dmem_addr, 32'd0);
    chk("rst_wdata", o_dmem_wdata, 32'd0);
    chk("rst_ld", o_ld_data, 32'd0);
    chk("rst_stall", {31'd0, o_stall}, 32'd0);
    @(negedge i_clk);
    i_reset = 1'b1;
    tick();

    run_acc("lw100", 1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1, 32'h100, 4'b1111, 32'h0, 32'hDEADBEEF);
    run_acc("lb103", 1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80112233, 1, 32'h100, 4'b1111, 32'h0, 32'hFFFFFF80);
    run_acc("lbu103", 1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80112233, 2, 32'h100, 4'b1111, 32'h0, 32'h00000080);
    run_acc("lhu102", 1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h80112233, 1, 32'h100, 4'b1111, 32'h0, 32'h00008011);
    run_acc("lh100", 1'b1, 1'b0, 3'b001, 32'h100, 32'h0, 32'h80112233, 1, 32'h100, 4'b1111, 32'h0, 32'h00002233);
    run_acc("lh102", 1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h80112233, 1, 32'h100, 4'b1111, 32'h0, 32'hFFFF8011);
    run_acc("sb201", 1'b0, 1'b1, 3'b000, 32'h201, 32'h000000A5, 32'h0, 1, 32'h200, 4'b0010, 32'hA5A5A5A5, 32'hFFFF8011);
    run_acc("sh202", 1'b0, 1'b1, 3'b001, 32'h202, 32'h00001234, 32'h0, 1, 32'h200, 4'b1100, 32'h12341234, 32'hFFFF8011);
    run_acc("sw_slow", 1'b0, 1'b1, 3'b010, 32'h204, 32'hCAFEF00D, 32'h0, 5, 32'h204, 4'b1111, 32'hCAFEF00D, 32'hFFFF8011);
    run_acc("lw_slow", 1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'h13579BDF, 5, 32'h300, 4'b1111, 32'h0, 32'h13579BDF);

    // Spurious ack while idle must not touch the load register or start a request.
    i_dmem_ack = 1'b1; i_dmem_rdata = 32'h55555555;
    tick();
    i_dmem_ack = 1'b0;
    chk("spur_ld", o_ld_data, 32'h13579BDF);
    chk("spur_req", {31'd0, o_dmem_req}, 32'd0);
    chk("spur_stall", {31'd0, o_stall}, 32'd0);
    tick();
    chk("spur_req2", {31'd0, o_dmem_req}, 32'd0);

`ifdef LSU_MISALIGN_TRAP_EN
    i_valid = 1'b1; i_mem_rd = 1'b1; i_funct3 = 3'b010; i_addr = 32'h102;
    #1;
    chk("mis_flag", {31'd0, o_misalign}, 32'd1);
    chk("mis_stall", {31'd0, o_stall}, 32'd0);
    tick();
    chk("mis_req", {31'd0, o_dmem_req}, 32'd0);
    chk("mis_ld", o_ld_data, 32'h13579BDF);
    i_valid = 1'b0; i_mem_rd = 1'b0;
    #1;
    chk("mis_flag_clr", {31'd0, o_misalign}, 32'd0);
    tick();
`else
    run_acc("lw102_forced", 1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 32'h0BADF00D, 1, 32'h100, 4'b1111, 32'h0, 32'h0BADF00D);
`endif

    // Asynchronous reset in the middle of a BUSY phase.
    i_valid = 1'b1; i_mem_rd = 1'b1; i_mem_wr = 1'b0; i_funct3 = 3'b010; i_addr = 32'h400;
    tick();
    chk("rstmid_busy_req", {31'd0, o_dmem_req}, 32'd1);
    i_reset = 1'b0;
    i_valid = 1'b0; i_mem_rd = 1'b0;
    #1;
    chk("rstmid_req", {31'd0, o_dmem_req}, 32'd0);
    chk("rstmid_ld", o_ld_data, 32'd0);
    chk("rstmid_stall", {31'd0, o_stall}, 32'd0);
    tick();
    i_reset = 1'b1;
    tick();
    chk("rstmid_idle_req", {31'd0, o_dmem_req}, 32'd0);
    run_acc("lw_after_rst", 1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'h89ABCDEF, 1, 32'h100, 4'b1111, 32'h0, 32'h89ABCDEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- MEM-stage load/store unit of the 5-stage forwarding pipeline. Sits between the EX/MEM register and the MEM/WB register.
- Converts EX/MEM load/store controls into a registered valid/ack data-memory transaction with byte enables.
- Aligns and sign/zero-extends load data into o_ld_data, which feeds the MEM/WB register's i_mem input.
- Raises o_stall while a transaction is outstanding, so the hazard unit freezes IF..EX/MEM and bubbles MEM/WB.

Parameters:
- ADDR_W, 32, data-memory byte-address width.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  reset, asynchronous, active-low
- i_valid  in  1  valid instruction in MEM
- i_mem_rd  in  1  load
- i_mem_wr  in  1  store; i_mem_rd and i_mem_wr are never both high
- i_funct3  in  3  000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
- i_addr  in  ADDR_W  byte address from the ALU
- i_wdata  in  32  store data (forwarded rs2)
- o_dmem_req  out  1  request valid
- o_dmem_we  out  1  write enable
- o_dmem_addr  out  ADDR_W  word-aligned address (low 2 bits 0)
- o_dmem_wdata  out  32  lane-replicated store data
- o_dmem_be  out  4  byte enables
- i_dmem_ack  in  1  one-cycle completion pulse; read data valid with it
- i_dmem_rdata  in  32  read word
- o_ld_data  out  32  formatted load result
- o_stall  out  1  MEM busy

Behaviour:
- Reset: state IDLE; o_dmem_req, o_dmem_we, o_dmem_be, o_dmem_addr, o_dmem_wdata, o_ld_data all 0.
- acc = i_valid & (i_mem_rd | i_mem_wr).
- FSM IDLE / BUSY / DONE.
- IDLE
  - acc=1: register addr/we/be/wdata; next state BUSY; o_stall=1 combinationally this cycle.
  - acc=0: o_stall=0.
- BUSY
  - o_dmem_req=1; all request fields held stable until ack; o_stall=1.
  - On i_dmem_ack: loads capture formatted rdata into o_ld_data; stores leave o_ld_data unchanged. Next state DONE.
  - Ack arriving in the first BUSY cycle is legal.
  - i_dmem_ack while not BUSY is ignored.
- DONE
  - o_dmem_req=0; o_stall=0, so the instruction advances into MEM/WB with o_ld_data valid.
  - Next state IDLE unconditionally. The following instruction is evaluated in IDLE next cycle; back-to-back accesses are never chained in DONE.
- Minimum access cost: 2 stall cycles (IDLE-detect, BUSY) + DONE cycle.
- Inputs are frozen by the hazard unit while o_stall=1. The block registers the request regardless, and changes to inputs during BUSY/DONE are ignored.
- Address: o_dmem_addr = {i_addr[ADDR_W-1:2], 2'b00}; off = i_addr[1:0].
- Store
  - SB: wdata = byte replicated x4; be = 4'b0001 << off.
  - SH: wdata = half replicated x2; be = 4'b0011 << {off[1],1'b0}.
  - SW: wdata unchanged; be = 4'b1111.
- Load: be = 4'b1111. Data selected from i_dmem_rdata by lane:
  - LB/LBU: byte at off, sign/zero-extended.
  - LH/LHU: half at off[1], sign/zero-extended.
  - LW: whole word.
- Unlisted funct3 values behave as word access.
- Misaligned (macro off): LH/SH ignore off[0]; LW/SW ignore off; access proceeds.
- Asynchronous reset mid-BUSY: state returns to IDLE immediately; request dropped. The memory is reset by the same net.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined: adds output o_misalign (1 bit).
- Condition: acc in IDLE with (half & off[0]) or (word & off!=0).
- Response: o_misalign=1 that cycle; no transaction issued; state stays IDLE; o_stall=0; o_ld_data unchanged. The trap unit flushes the instruction.
- Not defined: port absent; force-alignment as above.

Decomposition:
- Package lsu_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum lsu_state_e {IDLE, BUSY, DONE}, byte-enable width constant.
- One sub-module, lsu_load_align: combinational rdata + off + funct3 -> 32-bit extended load value.

Test Plan:
- LW addr 0x100, rdata 0xDEADBEEF, ack in first BUSY cycle -> o_dmem_addr 0x100, be 1111, o_stall high 2 cycles, DONE o_ld_data 0xDEADBEEF.
- LB addr 0x103, rdata 0x80112233 -> o_ld_data 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x102 -> 0x00008011.
- SB addr 0x201, wdata 0x000000A5 -> o_dmem_wdata 0xA5A5A5A5, be 0010, we 1; SH addr 0x202 wdata 0x1234 -> 0x12341234, be 1100.
- Ack delayed 5 cycles -> req/addr/be stable throughout, o_stall high 6 cycles, spurious ack in IDLE ignored.
- Reset asserted mid-BUSY -> req 0, state IDLE, o_ld_data 0 immediately; next LW completes normally.
- Macro on, LW addr 0x102 -> o_misalign 1, no req, o_stall 0; macro off same -> addr 0x100 access completes.
